// File: rtl/sample_iterator_if.sv
// rtl/sample_iterator_if.sv - R13 triangle/box inputs and R14 sample outputs of the sample iterator
`timescale 1ns/1ps
interface sample_iterator_if #(
  parameter int SIGFIG = 24,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
);
  logic signed [SIGFIG-1:0] tri_R13S   [VERTS][AXIS];
  logic        [SIGFIG-1:0] color_R13U [COLORS];
  logic signed [SIGFIG-1:0] box_R13S   [2][2];
  logic                     validTri_R13H;
  logic        [3:0]        subSample_RnnnnU;
  logic                     halt_RnnnnnL;
  logic signed [SIGFIG-1:0] tri_R14S   [VERTS][AXIS];
  logic        [SIGFIG-1:0] color_R14U [COLORS];
  logic signed [SIGFIG-1:0] sample_R14S [2];
  logic                     validSamp_R14H;

  modport master (
    output tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
    input  halt_RnnnnnL, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
  );

  modport slave (
    input  tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
    output halt_RnnnnnL, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
  );
endinterface

// File: rtl/sample_iterator.sv
// rtl/sample_iterator.sv - raster walk of every sample position inside a triangle bounding box
`timescale 1ns/1ps
module sample_iterator #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic              clk,
  input  logic              rst,
  sample_iterator_if.slave  bus
);
  localparam int W = SIGFIG + 1;

  typedef enum logic {WAIT, TEST} state_t;

  state_t                   state_q, state_d;
  logic signed [SIGFIG-1:0] tri_q   [VERTS][AXIS];
  logic signed [SIGFIG-1:0] tri_d   [VERTS][AXIS];
  logic        [SIGFIG-1:0] color_q [COLORS];
  logic        [SIGFIG-1:0] color_d [COLORS];
  logic signed [SIGFIG-1:0] ll_x_q, ll_x_d, ll_y_q, ll_y_d;
  logic signed [SIGFIG-1:0] ur_x_q, ur_x_d, ur_y_q, ur_y_d;
  logic signed [SIGFIG-1:0] x_q, x_d, y_q, y_d;
  logic        [SIGFIG-1:0] step_q, step_d, step_sel;
  logic                     valid_q, valid_d;
  logic signed [W-1:0]      nx, ny, ur_x_e, ur_y_e;
  logic                     inverted;
  int                       k;

  // Non-one-hot rates fall back to one sample per pixel.
  always_comb begin
    k = 0;
    case (bus.subSample_RnnnnU)
      4'b0100: k = 1;
      4'b0010: k = 2;
      4'b0001: k = 3;
      default: k = 0;
    endcase
    step_sel = SIGFIG'(1) << (RADIX - k);
  end

  // One extra bit so x+step never wraps past the box edge.
  assign nx       = {x_q[SIGFIG-1], x_q} + {1'b0, step_q};
  assign ny       = {y_q[SIGFIG-1], y_q} + {1'b0, step_q};
  assign ur_x_e   = {ur_x_q[SIGFIG-1], ur_x_q};
  assign ur_y_e   = {ur_y_q[SIGFIG-1], ur_y_q};
  assign inverted = (ll_x_q > ur_x_q) || (ll_y_q > ur_y_q);

  always_comb begin
    state_d = state_q;
    tri_d   = tri_q;
    color_d = color_q;
    ll_x_d  = ll_x_q;
    ll_y_d  = ll_y_q;
    ur_x_d  = ur_x_q;
    ur_y_d  = ur_y_q;
    step_d  = step_q;
    x_d     = x_q;
    y_d     = y_q;
    valid_d = valid_q;
    case (state_q)
      WAIT: begin
        valid_d = 1'b0;
        if (bus.validTri_R13H) begin
          tri_d   = bus.tri_R13S;
          color_d = bus.color_R13U;
          ll_x_d  = bus.box_R13S[0][0];
          ll_y_d  = bus.box_R13S[0][1];
          ur_x_d  = bus.box_R13S[1][0];
          ur_y_d  = bus.box_R13S[1][1];
          step_d  = step_sel;
          x_d     = bus.box_R13S[0][0];
          y_d     = bus.box_R13S[0][1];
          valid_d = 1'b1;
          state_d = TEST;
        end
      end
      TEST: begin
        // An inverted box stops after its lower-left sample.
        if (!inverted && (nx <= ur_x_e)) begin
          x_d = nx[SIGFIG-1:0];
        end else if (!inverted && (ny <= ur_y_e)) begin
          x_d = ll_x_q;
          y_d = ny[SIGFIG-1:0];
        end else begin
          valid_d = 1'b0;
          state_d = WAIT;
        end
      end
      default: state_d = WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= WAIT;
      for (int v = 0; v < VERTS; v++)
        for (int a = 0; a < AXIS; a++)
          tri_q[v][a] <= '0;
      for (int c = 0; c < COLORS; c++)
        color_q[c] <= '0;
      ll_x_q  <= '0;
      ll_y_q  <= '0;
      ur_x_q  <= '0;
      ur_y_q  <= '0;
      step_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tri_q   <= tri_d;
      color_q <= color_d;
      ll_x_q  <= ll_x_d;
      ll_y_q  <= ll_y_d;
      ur_x_q  <= ur_x_d;
      ur_y_q  <= ur_y_d;
      step_q  <= step_d;
      x_q     <= x_d;
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign bus.halt_RnnnnnL   = (state_q == WAIT);
  assign bus.tri_R14S       = tri_q;
  assign bus.color_R14U     = color_q;
  assign bus.sample_R14S[0] = x_q;
  assign bus.sample_R14S[1] = y_q;
  assign bus.validSamp_R14H = valid_q;
endmodule
